// File: rtl/alu_arbiter.sv
// Two-requester front end sharing a single ALU: round-robin grant, one
// transaction in flight, result held until the owning requester takes it.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; winner of the arbitration is accepted this cycle
// EXEC  | ALU is evaluated from the captured operands; result is registered
// RESP  | result is presented to the owner until its rsp_ready is high

module alu #(
   parameter int data_len = 4
) (
   input  logic [data_len-1:0] a,
   input  logic [data_len-1:0] b,
   input  logic [2:0]          func,
   output logic [data_len-1:0] y
);

   always_comb begin
      y = '0;
      case (func)
         3'b000:  y = a + b;
         3'b001:  y = a - b;
         3'b010:  y = ~a;
         3'b011:  y = a & b;
         3'b100:  y = a | b;
         3'b101:  y = a ^ b;
         3'b110:  y[0] = ($signed(a) < $signed(b));
         default: y[0] = (a == b);
      endcase
   end

endmodule

module alu_arbiter #(
   parameter int data_len = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0_valid,
   input  logic                req1_valid,
   output logic                req0_ready,
   output logic                req1_ready,
   input  logic [data_len-1:0] req0_a,
   input  logic [data_len-1:0] req1_a,
   input  logic [data_len-1:0] req0_b,
   input  logic [data_len-1:0] req1_b,
   input  logic [2:0]          req0_func,
   input  logic [2:0]          req1_func,
   output logic                rsp0_valid,
   output logic                rsp1_valid,
   input  logic                rsp0_ready,
   input  logic                rsp1_ready,
   output logic [data_len-1:0] rsp0_result,
   output logic [data_len-1:0] rsp1_result,
   output logic                busy,
   output logic                grant_id
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              state_q, state_d;
   logic                last_q;
   logic [data_len-1:0] cap_a, cap_b, res_q, alu_y;
   logic [2:0]          cap_func;
   logic                cap_id;
   logic                accept, win_id, owner_ready;

   alu #(.data_len(data_len)) u_alu (
      .a    (cap_a),
      .b    (cap_b),
      .func (cap_func),
      .y    (alu_y)
   );

   assign owner_ready = cap_id ? rsp1_ready : rsp0_ready;

   always_comb begin
      state_d    = state_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      win_id     = 1'b0;
      case (state_q)
         IDLE: begin
            // On a tie the requester not granted last time wins.
            if (req0_valid && req1_valid) win_id = ~last_q;
            else                          win_id = req1_valid;
            if (req0_valid || req1_valid) begin
               accept     = 1'b1;
               req0_ready = ~win_id;
               req1_ready = win_id;
               state_d    = EXEC;
            end
         end
         EXEC:    state_d = RESP;
         RESP:    if (owner_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         cap_a    <= '0;
         cap_b    <= '0;
         cap_func <= '0;
         cap_id   <= 1'b0;
         res_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cap_a    <= win_id ? req1_a    : req0_a;
            cap_b    <= win_id ? req1_b    : req0_b;
            cap_func <= win_id ? req1_func : req0_func;
            cap_id   <= win_id;
            last_q   <= win_id;
         end
         if (state_q == EXEC) res_q <= alu_y;
      end
   end

   assign busy        = (state_q != IDLE);
   assign grant_id    = busy & cap_id;
   assign rsp0_valid  = (state_q == RESP) & ~cap_id;
   assign rsp1_valid  = (state_q == RESP) &  cap_id;
   assign rsp0_result = rsp0_valid ? res_q : '0;
   assign rsp1_result = rsp1_valid ? res_q : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (data_len = 4): hand-computed results,
// arbitration order, latency, backpressure, reset abort and operand isolation.

module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req1_valid, req0_ready, req1_ready;
   logic [3:0] req0_a, req1_a, req0_b, req1_b;
   logic [2:0] req0_func, req1_func;
   logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [3:0] rsp0_result, rsp1_result;
   logic       busy, grant_id;

   int n_cmp = 0;
   int n_err = 0;

   alu_arbiter #(.data_len(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req1_valid  (req1_valid),
      .req0_ready  (req0_ready),
      .req1_ready  (req1_ready),
      .req0_a      (req0_a),
      .req1_a      (req1_a),
      .req0_b      (req0_b),
      .req1_b      (req1_b),
      .req0_func   (req0_func),
      .req1_func   (req1_func),
      .rsp0_valid  (rsp0_valid),
      .rsp1_valid  (rsp1_valid),
      .rsp0_ready  (rsp0_ready),
      .rsp1_ready  (rsp1_ready),
      .rsp0_result (rsp0_result),
      .rsp1_result (rsp1_result),
      .busy        (busy),
      .grant_id    (grant_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_req0_ready"}, 8'(req0_ready), 8'h0);
      chk({tag, "_req1_ready"}, 8'(req1_ready), 8'h0);
      chk({tag, "_rsp0_valid"}, 8'(rsp0_valid), 8'h0);
      chk({tag, "_rsp1_valid"}, 8'(rsp1_valid), 8'h0);
      chk({tag, "_rsp0_result"}, 8'(rsp0_result), 8'h0);
      chk({tag, "_rsp1_result"}, 8'(rsp1_result), 8'h0);
      chk({tag, "_busy"}, 8'(busy), 8'h0);
      chk({tag, "_grant_id"}, 8'(grant_id), 8'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   // Single requester transaction with its rsp_ready held high.
   task automatic run_txn(input string tag, input logic id, input logic [3:0] a,
                          input logic [3:0] b, input logic [2:0] f, input logic [3:0] exp);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_func = f;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_func = f;
      end
      #1;
      chk({tag, "_ready"}, 8'(id ? req1_ready : req0_ready), 8'h1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk({tag, "_exec_valid"}, 8'(rsp0_valid | rsp1_valid), 8'h0);
      tick();
      chk({tag, "_valid"}, 8'(id ? rsp1_valid : rsp0_valid), 8'h1);
      chk({tag, "_result"}, 8'(id ? rsp1_result : rsp0_result), 8'(exp));
      tick();
      chk({tag, "_done_busy"}, 8'(busy), 8'h0);
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0;
      req0_a = 0; req0_b = 0; req0_func = 0;
      req1_a = 0; req1_b = 0; req1_func = 0;
      rsp0_ready = 0; rsp1_ready = 0;

      do_reset();
      chk_idle_outputs("reset");

      // Basic req0 subtract 3-5 = E, two cycles accept-to-response
      req0_valid = 1; req0_a = 4'h3; req0_b = 4'h5; req0_func = 3'b001; rsp0_ready = 1;
      #1;
      chk("sub_req0_ready", 8'(req0_ready), 8'h1);
      chk("sub_req1_ready", 8'(req1_ready), 8'h0);
      chk("sub_busy_accept", 8'(busy), 8'h0);
      tick();
      req0_valid = 0;
      #1;
      chk("sub_busy_exec", 8'(busy), 8'h1);
      chk("sub_valid_exec", 8'(rsp0_valid), 8'h0);
      chk("sub_ready_exec", 8'(req0_ready), 8'h0);
      tick();
      chk("sub_busy_resp", 8'(busy), 8'h1);
      chk("sub_valid_resp", 8'(rsp0_valid), 8'h1);
      chk("sub_result", 8'(rsp0_result), 8'h0E);
      chk("sub_grant", 8'(grant_id), 8'h0);
      chk("sub_rsp1_valid", 8'(rsp1_valid), 8'h0);
      chk("sub_rsp1_result", 8'(rsp1_result), 8'h0);
      tick();
      chk("sub_busy_after", 8'(busy), 8'h0);
      chk("sub_valid_after", 8'(rsp0_valid), 8'h0);

      // Both valid continuously: grants alternate 0,1,0,1 from reset
      do_reset();
      req0_valid = 1; req0_a = 4'h7; req0_b = 4'h9; req0_func = 3'b000;
      req1_valid = 1; req1_a = 4'hA; req1_b = 4'h6; req1_func = 3'b101;
      rsp0_ready = 1; rsp1_ready = 1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr%0d_req0_ready", i), 8'(req0_ready), 8'((i % 2) == 0));
         chk($sformatf("rr%0d_req1_ready", i), 8'(req1_ready), 8'((i % 2) == 1));
         tick();
         chk($sformatf("rr%0d_grant", i), 8'(grant_id), 8'(i % 2));
         chk($sformatf("rr%0d_exec_ready", i), 8'(req0_ready | req1_ready), 8'h0);
         tick();
         if ((i % 2) == 0) begin
            chk($sformatf("rr%0d_rsp0_valid", i), 8'(rsp0_valid), 8'h1);
            chk($sformatf("rr%0d_rsp0_result", i), 8'(rsp0_result), 8'h00);
            chk($sformatf("rr%0d_rsp1_valid", i), 8'(rsp1_valid), 8'h0);
         end else begin
            chk($sformatf("rr%0d_rsp1_valid", i), 8'(rsp1_valid), 8'h1);
            chk($sformatf("rr%0d_rsp1_result", i), 8'(rsp1_result), 8'h0C);
            chk($sformatf("rr%0d_rsp0_valid", i), 8'(rsp0_valid), 8'h0);
         end
         tick();
      end
      req0_valid = 0; req1_valid = 0;
      tick();

      // Compare functions and the remaining logic ops
      run_txn("slt_neg",   1'b1, 4'hE, 4'h3, 3'b110, 4'h1);
      run_txn("slt_ovf",   1'b1, 4'h7, 4'h8, 3'b110, 4'h0);
      run_txn("eq",        1'b1, 4'h5, 4'h5, 3'b111, 4'h1);
      run_txn("neq",       1'b1, 4'h5, 4'h4, 3'b111, 4'h0);
      run_txn("not",       1'b0, 4'h5, 4'h0, 3'b010, 4'hA);
      run_txn("and",       1'b0, 4'hC, 4'hA, 3'b011, 4'h8);
      run_txn("or",        1'b0, 4'hC, 4'h3, 3'b100, 4'hF);
      run_txn("add_wrap",  1'b1, 4'hF, 4'h2, 3'b000, 4'h1);

      // Backpressure: rsp0 held off 5 cycles while req1 waits
      rsp0_ready = 0; rsp1_ready = 1;
      req0_valid = 1; req0_a = 4'hC; req0_b = 4'h3; req0_func = 3'b100;
      #1;
      chk("bp_req0_ready", 8'(req0_ready), 8'h1);
      tick();
      req0_valid = 0;
      req1_valid = 1; req1_a = 4'h9; req1_b = 4'h9; req1_func = 3'b000;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d_rsp0_valid", i), 8'(rsp0_valid), 8'h1);
         chk($sformatf("bp%0d_rsp0_result", i), 8'(rsp0_result), 8'h0F);
         chk($sformatf("bp%0d_req1_ready", i), 8'(req1_ready), 8'h0);
         chk($sformatf("bp%0d_rsp1_valid", i), 8'(rsp1_valid), 8'h0);
         tick();
      end
      rsp0_ready = 1;
      #1;
      chk("bp_release_req1_ready", 8'(req1_ready), 8'h0);
      tick();
      chk("bp_after_rsp0_valid", 8'(rsp0_valid), 8'h0);
      chk("bp_req1_accept", 8'(req1_ready), 8'h1);
      tick();
      req1_valid = 0;
      #1;
      chk("bp_req1_grant", 8'(grant_id), 8'h1);
      tick();
      chk("bp_req1_result", 8'(rsp1_result), 8'h02);
      tick();

      // Reset during EXEC aborts; last-grant restored so req0 wins the next tie
      rsp0_ready = 1; rsp1_ready = 1;
      req0_valid = 1; req0_a = 4'h1; req0_b = 4'h1; req0_func = 3'b000;
      #1;
      chk("abort_accept", 8'(req0_ready), 8'h1);
      tick();
      req0_valid = 0;
      rst = 1;
      #1;
      chk("abort_in_exec", 8'(busy), 8'h1);
      tick();
      rst = 0;
      #1;
      chk_idle_outputs("abort");
      tick();
      chk("abort_no_rsp0", 8'(rsp0_valid), 8'h0);
      chk("abort_no_rsp1", 8'(rsp1_valid), 8'h0);
      req0_valid = 1; req0_a = 4'h2; req0_b = 4'h3; req0_func = 3'b000;
      req1_valid = 1; req1_a = 4'h0; req1_b = 4'h0; req1_func = 3'b000;
      #1;
      chk("abort_tie_req0", 8'(req0_ready), 8'h1);
      chk("abort_tie_req1", 8'(req1_ready), 8'h0);
      tick();
      req0_valid = 0; req1_valid = 0;
      tick();
      chk("abort_tie_result", 8'(rsp0_result), 8'h05);
      tick();

      // Operand changes after acceptance must not reach the result
      req0_valid = 1; req0_a = 4'h6; req0_b = 4'h2; req0_func = 3'b001;
      #1;
      chk("iso_accept", 8'(req0_ready), 8'h1);
      tick();
      req0_a = 4'hF; req0_b = 4'hF; req0_func = 3'b111;
      tick();
      chk("iso_result", 8'(rsp0_result), 8'h04);
      chk("iso_ready_resp", 8'(req0_ready), 8'h0);
      req0_a = 4'h0; req0_b = 4'h9; req0_func = 3'b000;
      #1;
      chk("iso_result_late", 8'(rsp0_result), 8'h04);
      req0_valid = 0;
      tick();
      chk("iso_done", 8'(busy), 8'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
